lu_bit_serial_ctrl: RTL and testbench

- Bit-serial sequencer placed around the team's 1-bit 2:1 gate-level mux in the logic-unit (LU) datapath.
- Upstream side: accepts a parallel operand pair plus a per-bit select pattern through a valid/ready handshake, then drives the mux a/b/select inputs one bit per clock, LSB first.
- Downstream side: captures the mux output z each cycle into a result shift register and presents the assembled word through a second valid/ready handshake.

---
 rtl/lu_pkg.sv | 16 +
 rtl/lu_bit_serial_ctrl.sv | 106 ++++++++++
 tb/tb_lu_bit_serial_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared logic-unit definitions: sequencer state encoding, default width,
// and the 2:1 mux truth table used by benches that model the gate-level mux.
package lu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } lu_state_e;

    localparam int LU_WIDTH = 8;

    // Indexed by {sel, b, a}; bit value is z = sel ? b : a.
    localparam logic [7:0] LU_MUX_TT = 8'hCA;

endpackage

// File: rtl/lu_bit_serial_ctrl.sv
// Bit-serial sequencer around the 1-bit 2:1 mux: latches an operand pair,
// streams it LSB-first into the mux and reassembles the mux output as a word.
module lu_bit_serial_ctrl
    import lu_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sel,
    output logic             mux_a,
    output logic             mux_b,
    output logic             mux_sel,
    input  logic             mux_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    lu_state_e        r_state;
    lu_state_e        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sel;
    logic [WIDTH-1:0] r_res;
    logic             w_accept;
    logic             w_last;
    logic             w_shift;

    assign w_shift  = (r_state == ST_SHIFT);
    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The counter parks on the last bit rather than wrapping; the next
    // acceptance clears it anyway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sel <= '0;
            r_res <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= in_a;
            r_b   <= in_b;
            r_sel <= in_sel;
            r_res <= '0;
        end else if (w_shift) begin
            r_res[r_cnt] <= mux_z;
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Mux drive comes only from registers, so there is no in_* to mux_* path.
    assign mux_a     = w_shift & r_a[r_cnt];
    assign mux_b     = w_shift & r_b[r_cnt];
    assign mux_sel   = w_shift & r_sel[r_cnt];

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_res;

endmodule

// File: tb/tb_lu_bit_serial_ctrl.sv
// Directed bench for lu_bit_serial_ctrl with a behavioural mux and a
// word-level reference model checked every cycle.
module tb_lu_bit_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_sel;
    logic         mux_a;
    logic         mux_b;
    logic         mux_sel;
    logic         mux_z;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    lu_bit_serial_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sel   (in_sel),
        .mux_a    (mux_a),
        .mux_b    (mux_b),
        .mux_sel  (mux_sel),
        .mux_z    (mux_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    assign mux_z = mux_sel ? mux_b : mux_a;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: m_k = -1 idle, 0..W-1 driving bit m_k, W holding the result.
    int           m_k = -1;
    logic [W-1:0] m_a, m_b, m_sel;

    function automatic logic [W-1:0] m_word();
        return (m_a & ~m_sel) | (m_b & m_sel);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k = -1;
        end else if (m_k < 0) begin
            if (in_valid) begin
                m_k   = 0;
                m_a   = in_a;
                m_b   = in_b;
                m_sel = in_sel;
            end
        end else if (m_k < W) begin
            m_k++;
        end else if (out_ready) begin
            m_k = -1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (m_k < 0) begin
                chk("idle_ctrl", 32'({in_ready, busy, out_valid, mux_a, mux_b, mux_sel}), 32'h20);
            end else if (m_k < W) begin
                chk("shift_ctrl", 32'({in_ready, busy, out_valid, mux_a, mux_b, mux_sel}),
                    32'({3'b010, m_a[m_k], m_b[m_k], m_sel[m_k]}));
            end else begin
                chk("done_ctrl", 32'({in_ready, busy, out_valid, mux_a, mux_b, mux_sel}), 32'h18);
                chk("done_data", 32'(out_data), 32'(m_word()));
            end
        end
    end

    logic [W-1:0] got[$];
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                        output int lat, output logic [W-1:0] res);
        in_a     = a;
        in_b     = b;
        in_sel   = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            tick();
            lat++;
        end
        res = out_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [W-1:0] res;
        int           acc[3];
        int           n;
        logic         rdy;
        logic [W-1:0] wa[3];
        logic [W-1:0] wb[3];
        logic [W-1:0] ws[3];

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_sel    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({in_ready, busy, out_valid, mux_a, mux_b, mux_sel}), 32'h20);
        chk("reset_data", 32'(out_data), 32'h0);
        reset = 1'b0;
        tick();

        // Basic mix with single-cycle out_valid pulse
        send(8'hA5, 8'h3C, 8'hF0, lat, res);
        chk("basic_latency", 32'(lat), 32'd8);
        chk("basic_data", 32'(res), 32'h35);
        tick();
        chk("basic_pulse", 32'(out_valid), 32'h0);

        send(8'hA5, 8'h3C, 8'h00, lat, res);
        chk("all_a", 32'(res), 32'hA5);
        tick();
        send(8'hA5, 8'h3C, 8'hFF, lat, res);
        chk("all_b", 32'(res), 32'h3C);
        tick();

        // Bit order: only bit 0 of a is set
        in_a = 8'h01; in_b = 8'h00; in_sel = 8'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bitorder_first", 32'(mux_a), 32'h1);
        tick();
        chk("bitorder_second", 32'(mux_a), 32'h0);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk("bitorder_data", 32'(out_data), 32'h01);
        tick();

        // Backpressure in DONE with a stray in_valid pulse
        out_ready = 1'b0;
        send(8'hA5, 8'h3C, 8'hF0, lat, res);
        chk("bp_data", 32'(res), 32'h35);
        for (int i = 0; i < 3; i++) begin
            in_a = 8'hFF; in_b = 8'h00; in_sel = 8'h00;
            in_valid = (i == 1);
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h35);
            chk("bp_hold_ctrl", 32'({in_ready, out_valid}), 32'h1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release", 32'({in_ready, out_valid, busy}), 32'h4);
        send(8'h11, 8'h22, 8'h0F, lat, res);
        chk("bp_next_word", 32'(res), 32'h12);
        tick();

        // Reset after four SHIFT cycles
        in_a = 8'hA5; in_b = 8'h3C; in_sel = 8'hF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("midreset_ctrl", 32'({in_ready, busy, out_valid, mux_a, mux_b, mux_sel}), 32'h20);
        chk("midreset_data", 32'(out_data), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        send(8'hFF, 8'h00, 8'h0F, lat, res);
        chk("after_reset_data", 32'(res), 32'hF0);
        tick();

        // Back-to-back words with in_valid and out_ready held high
        got.delete();
        wa = '{8'hA5, 8'h01, 8'hFF};
        wb = '{8'h3C, 8'h00, 8'h00};
        ws = '{8'hF0, 8'h00, 8'h0F};
        n = 0;
        in_a = wa[0]; in_b = wb[0]; in_sel = ws[0];
        in_valid = 1'b1;
        for (int t = 0; t < 60 && n < 3; t++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                acc[n] = cyc;
                n++;
                if (n < 3) begin
                    in_a = wa[n]; in_b = wb[n]; in_sel = ws[n];
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(n), 32'd3);
        chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd10);
        chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd10);
        repeat (12) tick();
        chk("b2b_results", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("b2b_res0", 32'(got[0]), 32'h35);
            chk("b2b_res1", 32'(got[1]), 32'h01);
            chk("b2b_res2", 32'(got[2]), 32'hF0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
